binsearch_engine: RTL and testbench

- Parametrised successor to the fixed 32x8 binary-search ASM.
- Searches an external sorted (ascending, unsigned) synchronous RAM of DEPTH = 2**ADDR_W words for a key.
- Two modes: exact match with early exit, or lower bound (first index holding a word >= key).
- Reports location, found flag, probe count and cycle count; sits between board I/O sync logic and a RAM block.

---
 rtl/binsearch_engine.sv | 203 ++++++++++++++++++++
 tb/tb_binsearch_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/binsearch_engine.sv
// Binary search over an external sorted synchronous RAM.
// Exact match with early exit, or lower bound (first word >= key).
module binsearch_engine #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   loc,
    output logic              found,
    output logic [ADDR_W:0]   probes,
    output logic [CNT_W-1:0]  cycles
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int WCW = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST =
        WCW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_A = (ADDR_W+1)'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   lo_q, lo_d;
    logic [ADDR_W:0]   hi_q, hi_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              mode_q, mode_d;
    logic              eq_q, eq_d;
    logic [ADDR_W:0]   prb_q, prb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   loc_q, loc_d;
    logic              found_q, found_d;
    logic [ADDR_W:0]   probes_q, probes_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] mid;
    logic [ADDR_W:0]   mid_up;
    logic [ADDR_W:0]   lo_n;
    logic [ADDR_W:0]   hi_n;
    logic              eq_n;
    logic              lt;
    logic              hit;
    logic              xhit;
    logic              fin;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // lo < hi keeps the midpoint inside the RAM
    assign mid    = ADDR_W'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
    assign mid_up = {1'b0, mid} + ONE_A;

    assign lt   = mem_rdata < key_q;
    assign hit  = mem_rdata == key_q;
    assign xhit = !mode_q && hit;
    assign lo_n = lt ? mid_up : lo_q;
    assign hi_n = lt ? hi_q : {1'b0, mid};
    assign eq_n = lt ? eq_q : hit;
    assign fin  = xhit || !(lo_n < hi_n);

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        key_d    = key_q;
        mode_d   = mode_q;
        eq_d     = eq_q;
        prb_d    = prb_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        loc_d    = loc_q;
        found_d  = found_q;
        probes_d = probes_q;
        cycles_d = cycles_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    mode_d  = mode;
                    lo_d    = '0;
                    hi_d    = DEPTH_V;
                    eq_d    = 1'b0;
                    prb_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                addr_d  = mid;
                prb_d   = prb_q + ONE_A;
                cnt_d   = sat_inc(cnt_q);
                wcnt_d  = '0;
                state_d = (MEM_LAT == 1) ? S_CMP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = sat_inc(cnt_q);
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_CMP;
                end else begin
                    wcnt_d = wcnt_q + WAIT_ONE;
                end
            end
            S_CMP: begin
                cnt_d = sat_inc(cnt_q);
                lo_d  = lo_n;
                hi_d  = hi_n;
                eq_d  = eq_n;
                if (fin) begin
                    // counts this compare cycle plus the DONE cycle
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    probes_d = prb_q;
                    cycles_d = sat_inc(sat_inc(cnt_q));
                    if (xhit) begin
                        loc_d   = {1'b0, mid};
                        found_d = 1'b1;
                    end else begin
                        loc_d   = mode_q ? lo_n : '0;
                        found_d = mode_q && eq_n;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            key_q    <= '0;
            mode_q   <= 1'b0;
            eq_q     <= 1'b0;
            prb_q    <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            addr_q   <= '0;
            loc_q    <= '0;
            found_q  <= 1'b0;
            probes_q <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            key_q    <= key_d;
            mode_q   <= mode_d;
            eq_q     <= eq_d;
            prb_q    <= prb_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            loc_q    <= loc_d;
            found_q  <= found_d;
            probes_q <= probes_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
    assign mem_rd_en = state_q == S_ISSUE;
    assign mem_addr  = mem_rd_en ? mid : addr_q;
    assign loc       = loc_q;
    assign found     = found_q;
    assign probes    = probes_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_binsearch_engine.sv
// Bench for binsearch_engine: directed cases plus random keys
// against a linear-scan reference, at read latency 1 and 3.
module tb_binsearch_engine;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset   [2];
    logic          start   [2];
    logic          mode_in [2];
    logic [DW-1:0] key_in  [2];
    logic [AW-1:0] addr    [2];
    logic          rd_en   [2];
    logic [DW-1:0] rdata   [2];
    logic          busy    [2];
    logic          done    [2];
    logic [AW:0]   loc     [2];
    logic          found   [2];
    logic [AW:0]   probes  [2];
    logic [CW-1:0] cycles  [2];

    logic [DW-1:0] mem [2][DEPTH];
    logic [DW-1:0] p1, p2;

    binsearch_engine #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1), .CNT_W(CW)
    ) u_dut1 (
        .clk(clk), .reset(reset[0]), .start(start[0]),
        .key(key_in[0]), .mode(mode_in[0]),
        .mem_addr(addr[0]), .mem_rd_en(rd_en[0]),
        .mem_rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
        .loc(loc[0]), .found(found[0]), .probes(probes[0]),
        .cycles(cycles[0])
    );

    binsearch_engine #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3), .CNT_W(CW)
    ) u_dut3 (
        .clk(clk), .reset(reset[1]), .start(start[1]),
        .key(key_in[1]), .mode(mode_in[1]),
        .mem_addr(addr[1]), .mem_rd_en(rd_en[1]),
        .mem_rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
        .loc(loc[1]), .found(found[1]), .probes(probes[1]),
        .cycles(cycles[1])
    );

    always @(posedge clk) begin
        if (rd_en[0]) rdata[0] <= mem[0][addr[0]];
    end

    always @(posedge clk) begin
        p1       <= rd_en[1] ? mem[1][addr[1]] : 8'hA5;
        p2       <= p1;
        rdata[1] <= p2;
    end

    int n_checks = 0;
    int n_pass   = 0;

    int          r_n, r_rd, r_busy, r_b2b;
    bit          r_got;
    logic [AW:0] r_loc, r_probes;
    logic        r_found;
    logic [CW-1:0] r_cycles;
    int          aq[$];
    int          ex[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic run(input int d, input logic [7:0] k, input logic m,
                       input int poke, input bit poke_done);
        int  n;
        bit  prev;
        aq.delete();
        r_rd = 0; r_busy = 0; r_b2b = 0; r_got = 0; r_n = 0;
        n = 0; prev = 0;
        @(negedge clk);
        start[d] = 1'b1; key_in[d] = k; mode_in[d] = m;
        @(negedge clk);
        key_in[d] = ~k; mode_in[d] = ~m;
        while (!r_got && n < 300) begin
            n++;
            start[d] = (n == poke);
            if (busy[d]) r_busy++;
            if (rd_en[d]) begin
                r_rd++;
                if (prev) r_b2b++;
                aq.push_back(int'(addr[d]));
            end
            prev = rd_en[d];
            if (done[d]) begin
                r_got = 1; r_n = n;
                r_loc = loc[d]; r_found = found[d];
                r_probes = probes[d]; r_cycles = cycles[d];
            end else begin
                @(negedge clk);
            end
        end
        check("timeout", 32'(r_got), 32'd1);
        start[d] = poke_done;
        @(negedge clk);
        start[d] = 1'b0;
        check("done_pulse", 32'(done[d]), 32'd0);
        check("idle_after", 32'(busy[d]), 32'd0);
    endtask

    task automatic check_res(input int eloc, input int efound,
                             input int eprb, input int ecyc);
        check("loc", 32'(r_loc), eloc);
        check("found", 32'(r_found), efound);
        check("probes", 32'(r_probes), eprb);
        check("cycles", 32'(r_cycles), ecyc);
        check("cyc_meas", r_n, ecyc);
        check("busy_cnt", r_busy, ecyc);
        check("rd_cnt", r_rd, eprb);
        check("rd_b2b", r_b2b, 0);
    endtask

    task automatic check_addrs();
        check("naddr", aq.size(), ex.size());
        foreach (ex[i]) begin
            if (i < aq.size()) check("addr", aq[i], ex[i]);
        end
    endtask

    task automatic check_idle(input int d);
        check("z_busy", 32'(busy[d]), 0);
        check("z_done", 32'(done[d]), 0);
        check("z_rden", 32'(rd_en[d]), 0);
        check("z_addr", 32'(addr[d]), 0);
        check("z_loc", 32'(loc[d]), 0);
        check("z_found", 32'(found[d]), 0);
        check("z_probes", 32'(probes[d]), 0);
        check("z_cycles", 32'(cycles[d]), 0);
    endtask

    task automatic rand_check(input int d, input logic [7:0] k,
                              input logic m);
        int  lb, lat, p;
        bit  has;
        lb = DEPTH;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (mem[d][i] >= k) lb = i;
        has = (lb < DEPTH) && (mem[d][lb] == k);
        lat = (d == 0) ? 1 : 3;
        p = int'(r_probes);
        check("r_found", 32'(r_found), 32'(has));
        if (m) begin
            check("r_lb_loc", 32'(r_loc), lb);
            check("r_lb_prb", 32'(p == AW || p == AW + 1), 1);
        end else begin
            if (has) check("r_ex_word", 32'(mem[d][r_loc[AW-1:0]]), 32'(k));
            else     check("r_ex_loc", 32'(r_loc), 0);
            check("r_ex_prb", 32'(p >= 1 && p <= AW + 1), 1);
        end
        check("r_cycles", 32'(r_cycles), p * (lat + 1) + 1);
        check("r_meas", r_n, p * (lat + 1) + 1);
        check("r_rd", r_rd, p);
        check("r_b2b", r_b2b, 0);
    endtask

    initial begin
        logic [7:0] k;
        logic       m;
        int         v;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; start[d] = 1'b0;
            key_in[d] = '0; mode_in[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[d][i] = 8'(2 * i + 2);
        end
        repeat (3) @(negedge clk);
        reset[0] = 1'b0; reset[1] = 1'b0;
        check_idle(0);
        check_idle(1);

        run(0, 8'd34, 1'b0, 0, 0);
        check_res(16, 1, 1, 3);
        ex = '{16};
        check_addrs();

        run(0, 8'd2, 1'b1, 0, 0);
        check_res(0, 1, 6, 13);
        ex = '{16, 8, 4, 2, 1, 0};
        check_addrs();

        run(0, 8'd65, 1'b1, 0, 0);
        check_res(32, 0, 5, 11);
        ex = '{16, 24, 28, 30, 31};
        check_addrs();

        run(0, 8'd35, 1'b1, 0, 0);
        check_res(17, 0, 5, 11);
        run(0, 8'd35, 1'b0, 0, 0);
        check_res(0, 0, 5, 11);
        run(0, 8'd1, 1'b0, 0, 0);
        check_res(0, 0, 6, 13);

        // start mid-search and in the DONE cycle must be ignored
        run(0, 8'd2, 1'b1, 4, 1);
        check_res(0, 1, 6, 13);
        ex = '{16, 8, 4, 2, 1, 0};
        check_addrs();
        repeat (3) @(negedge clk);
        check("hold_found", 32'(found[0]), 1);
        check("hold_probes", 32'(probes[0]), 6);
        check("hold_busy", 32'(busy[0]), 0);

        // reset during COMPARE, then reset together with start
        @(negedge clk);
        start[0] = 1'b1; key_in[0] = 8'd2; mode_in[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("rst_issue", 32'(rd_en[0]), 1);
        @(negedge clk);
        check("rst_cmp_busy", 32'(busy[0]), 1);
        reset[0] = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        check_idle(0);
        @(negedge clk);
        reset[0] = 1'b0; start[0] = 1'b0;
        check_idle(0);
        v = 0;
        repeat (6) begin
            @(negedge clk);
            if (done[0] || busy[0]) v++;
        end
        check("rst_quiet", v, 0);
        run(0, 8'd65, 1'b1, 0, 0);
        check_res(32, 0, 5, 11);

        for (int t = 0; t < 200; t++) begin
            k = 8'($urandom_range(0, 70));
            m = 1'($urandom_range(0, 1));
            run(0, k, m, 0, 0);
            rand_check(0, k, m);
        end

        run(1, 8'd2, 1'b1, 0, 0);
        check_res(0, 1, 6, 25);
        ex = '{16, 8, 4, 2, 1, 0};
        check_addrs();

        v = $urandom_range(0, 20);
        for (int i = 0; i < DEPTH; i++) begin
            mem[1][i] = 8'(v);
            v += $urandom_range(0, 7);
        end
        for (int t = 0; t < 200; t++) begin
            k = 8'($urandom_range(0, 250));
            m = 1'($urandom_range(0, 1));
            run(1, k, m, 0, 0);
            rand_check(1, k, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
